// File: rtl/riscv_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the core's data-memory port.
// Stores commit once per core cycle (on the rising edge of clk3), bytes are
// queued in a small FIFO and shifted out LSB first on txd.
module riscv_uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_F000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        x_reset,
    input  logic        clk3,
    input  logic [31:0] addr,
    input  logic        write_en,
    input  logic [31:0] wdata,
    output logic        hit,
    output logic [31:0] dout,
    output logic        txd,
    output logic        irq_empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic             clk3_q;
    logic [15:0]      bauddiv;
    logic [15:0]      div_q;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             overflow;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       count8;
    logic             full;
    logic             empty;
    logic             busy;
    logic             commit;
    logic             wr_txdata;
    logic             wr_status;
    logic             wr_baud;
    logic             push;
    logic             pop;
    logic             bit_end;
    logic             unused_ok;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    // clk3 stays high for more than one clk; only its rising edge marks the store
    assign commit    = hit & write_en & clk3 & ~clk3_q;
    assign wr_txdata = commit & (addr[3:2] == 2'd0);
    assign wr_status = commit & (addr[3:2] == 2'd1);
    assign wr_baud   = commit & (addr[3:2] == 2'd2);

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign busy    = (state != IDLE);
    assign pop     = (state == IDLE) & ~empty;
    // A full FIFO still accepts a byte when the transmitter drains one in the same cycle
    assign push    = wr_txdata & (~full | pop);
    assign bit_end = (baud_cnt == div_q - 16'd1);
    assign count8  = 8'(count);

    assign unused_ok = &{1'b0, addr[1:0], wdata[31:16]};

    // Read mux; everything outside the window or write-only reads as zero
    always_comb begin
        dout = '0;
        if (hit) begin
            case (addr[3:2])
                2'd1:    dout = {16'h0, count8, 4'h0, overflow, empty, full, busy};
                2'd2:    dout = {16'h0, bauddiv};
                default: dout = '0;
            endcase
        end
    end

    // Previous clk3 level for store edge detection
    always_ff @(posedge clk) begin
        if (x_reset) clk3_q <= 1'b0;
        else         clk3_q <= clk3;
    end

    // Baud divider register and sticky overflow flag
    always_ff @(posedge clk) begin
        if (x_reset) begin
            bauddiv  <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (wr_baud && (wdata[15:0] != 16'd0)) bauddiv <= wdata[15:0];
            if (wr_status && wdata[3])             overflow <= 1'b0;
            else if (wr_txdata && full && !pop)    overflow <= 1'b1;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (x_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the pointers gate access
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata[7:0];
    end

    // Frame serialiser; div_q is captured at pop so divider writes apply per frame
    always_ff @(posedge clk) begin
        if (x_reset) begin
            state    <= IDLE;
            txd      <= 1'b1;
            div_q    <= DEFAULT_DIV;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        div_q    <= bauddiv;
                        baud_cnt <= '0;
                        state    <= START;
                        txd      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                        txd      <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    txd <= 1'b1;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    // Interrupt when nothing is queued and the line is idle
    always_ff @(posedge clk) begin
        if (x_reset) irq_empty <= 1'b1;
        else         irq_empty <= empty & (state == IDLE);
    end
endmodule

// File: doc/riscv_uart_tx_mmio.md
Name: riscv_uart_tx_mmio

Overview:
- Memory-mapped UART transmitter that responds to the core's data-memory port (addr / write_en / wdata / dout), i.e. the target side of the core's load/store bus.
- Sits beside the data RAM. The top routes stores to it when `hit` is high, and selects its `dout` on loads.
- Buffers bytes in a small FIFO and serialises them 8N1 on `txd`. Exposes a status register and a baud-divider register.

Parameters:
- BASE_ADDR, 32'h0000_F000, base of the 16-byte register window; must be 16-byte aligned.
- FIFO_DEPTH, 8, number of TX FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 16'd16, reset value of BAUDDIV (clk cycles per bit).

Ports:
- clk, input, 1, system clock (undivided).
- x_reset, input, 1, synchronous, active-high reset.
- clk3, input, 1, divided core clock from the clock generator, sampled in the clk domain.
- addr, input, 32, byte address from the core ALU.
- write_en, input, 1, store enable from the decoder (held high for a whole core cycle).
- wdata, input, 32, store data after rs2 masking.
- hit, output, 1, combinational; 1 when addr[31:4] == BASE_ADDR[31:4].
- dout, output, 32, combinational read data; 0 when hit=0.
- txd, output, 1, serial output; idles high.
- irq_empty, output, 1, registered; 1 when the FIFO is empty and the FSM is IDLE.

Behaviour:
- Register map (offset = addr[3:2]):
  - 0 TXDATA: write-only; reads 0.
  - 1 STATUS: read {count[7:0] at bits [15:8], overflow, empty, full, busy at bits [3:0]}.
  - 2 BAUDDIV: R/W, 16 bits, zero-extended on read.
  - 3: reserved; reads 0, writes ignored.
- Write commit:
  - Register `clk3_q` <= clk3 on every clk edge.
  - A commit occurs in exactly one clk cycle per core store: when hit & write_en & clk3 & ~clk3_q.
  - This prevents the triple write that would otherwise occur across the 3-clk core cycle.
- TXDATA commit:
  - If the FIFO is not full, push wdata[7:0].
  - If the FIFO is full and no pop occurs in the same cycle, drop the byte and set the sticky overflow flag.
  - If the FIFO is full and a pop occurs in the same cycle, accept the push; count is unchanged.
- STATUS commit: wdata[3]=1 clears overflow. All other bits are ignored.
- BAUDDIV commit:
  - Load wdata[15:0]; a value of 0 is ignored and the old value is kept.
  - A change takes effect at the next frame start. The divider is latched into `div_q` on pop.
- FIFO:
  - Circular buffer with rd/wr pointers of width log2(FIFO_DEPTH); pointers wrap mod FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If FIFO not empty: pop into `shreg`, latch div_q, clear baud_cnt, go to START next cycle.
  - START: txd=0 for div_q cycles, then go to DATA with bit_cnt=0.
  - DATA: txd=shreg[0] (LSB first). Each bit lasts div_q cycles; at the end of each bit, shift shreg right and increment bit_cnt. After bit 7, go to STOP.
  - STOP: txd=1 for div_q cycles, then go to IDLE.
  - Frame length is 10*div_q cycles. Back-to-back frames have exactly 1 idle cycle (txd=1) between them, spent in IDLE.
  - baud_cnt counts 0..div_q-1; the bit boundary is baud_cnt == div_q-1.
- busy = (state != IDLE).
- Reset (synchronous, also mid-frame); all take effect on the next clk edge:
  - state=IDLE, txd=1.
  - FIFO pointers and count = 0.
  - overflow=0, BAUDDIV=DEFAULT_DIV, div_q=DEFAULT_DIV, clk3_q=0.
  - irq_empty=1.
  - Any partial frame is abandoned; no glitch low on txd.
- Combinational outputs (hit, dout) do not depend on reset except through register contents.
- Loads have no side effects.

Test Plan:
- Reset, then read STATUS → dout=32'h0000_0004 (empty=1, count=0); txd=1; irq_empty=1.
- Write BAUDDIV=4, then TXDATA=8'hA5 with write_en held for 3 clk → exactly one byte is pushed.
  - txd waveform: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. Total 40 cycles.
  - busy falls after 40 cycles.
- With DIV=4, push 10 bytes 0x00..0x09 while the first frame is in progress:
  - The first byte pops at once and 8 are buffered; byte 0x09 is dropped.
  - STATUS after the pushes: full=1, overflow=1, count=8.
  - Bytes 0x00..0x08 are transmitted with a 1-cycle gap between frames.
- Write STATUS with wdata=32'h8 → overflow clears. Write BAUDDIV=0 → reads back the previous value (4).
- Change BAUDDIV from 4 to 8 mid-frame → the current frame keeps 4-cycle bits; the next frame uses 8-cycle bits (80 cycles).
- Assert x_reset for 1 cycle mid-DATA → txd=1 next cycle, STATUS=32'h4, BAUDDIV=16. A subsequent push transmits normally.
